// File: rtl/alu_packet_tx_if.sv
// Ready/valid channel used on both sides of the ALU response packetizer.
// The word side and the byte side differ only in the width of data.
interface alu_packet_tx_if #(
    parameter int width_p = 8
);
    logic [width_p-1:0] data;
    logic               valid;
    logic               ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/alu_packet_tx.sv
// Frames one ALU result word per packet: opcode, reserved byte, 16-bit length,
// then the payload bytes least-significant first.
module alu_packet_tx #(
    parameter int          width_p  = 32,
    parameter logic [7:0]  opcode_p = 8'hEC
) (
    input  logic            clk_i,
    input  logic            reset_i,
    alu_packet_tx_if.slave  in_if,
    alu_packet_tx_if.master out_if
);
    localparam int B     = width_p / 8;
    localparam int N     = 4 + B;
    localparam int IDX_W = $clog2(N);

    localparam logic [15:0]      LEN      = 16'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [width_p-1:0] word_q;
    logic [7:0]         frame [N];
    logic               last;
    logic               accept;

    assign last   = (idx == LAST_IDX);
    // ready_i feeds ready_o combinationally so the next word can be taken
    // on the same edge as the final byte, giving gap-free back-to-back packets.
    assign in_if.ready  = (state == IDLE) || (last && out_if.ready);
    assign accept       = in_if.valid && in_if.ready;
    assign out_if.valid = (state == SEND);
    assign out_if.data  = frame[idx];

    always_comb begin
        frame[0] = opcode_p;
        frame[1] = 8'h00;
        frame[2] = LEN[7:0];
        frame[3] = LEN[15:8];
        for (int i = 0; i < B; i++) begin
            frame[4 + i] = word_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= SEND;
                        idx   <= '0;
                    end
                end
                SEND: begin
                    if (out_if.ready) begin
                        if (last) begin
                            idx <= '0;
                            if (!in_if.valid) begin
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Payload holding register carries no reset; only control is reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            word_q <= in_if.data;
        end
    end
endmodule
